frogger_player_fsm: RTL and testbench

Parametrised next-generation player controller for the Frogger game core. It owns the frog's grid position, score, lives and game-state machine. It adds log drift, water death, a lives/respawn sequence, game-over/restart, and configurable playfield size. It sits between the debounced button inputs and the renderer / collision / bitmap-lookup blocks.

---
 rtl/frogger_pkg.sv | 25 ++
 rtl/frogger_player_fsm_if.sv | 35 +++
 rtl/frogger_btn_edge.sv | 24 ++
 rtl/frogger_player_fsm.sv | 199 +++++++++++++++++++
 tb/tb_frogger_player_fsm.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/frogger_pkg.sv
// rtl/frogger_pkg.sv - shared frogger state encoding, tile codes and playfield defaults
package frogger_pkg;

  typedef enum logic [1:0] {
    ST_PLAY      = 2'd0,
    ST_DYING     = 2'd1,
    ST_GAME_OVER = 2'd2
  } state_e;

  localparam logic [3:0] TILE_GRASS = 4'd0;
  localparam logic [3:0] TILE_ROAD  = 4'd1;
  localparam logic [3:0] TILE_WATER = 4'd2;
  localparam logic [3:0] TILE_LOG   = 4'd3;
  localparam logic [3:0] TILE_GOAL  = 4'd4;

  localparam int DEF_GAME_WIDTH  = 20;
  localparam int DEF_GAME_HEIGHT = 15;

  // Bit positions of the buttons inside the packed edge-detector vector.
  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 3;

endpackage

// File: rtl/frogger_player_fsm_if.sv
// rtl/frogger_player_fsm_if.sv - button/tile inputs and position/score outputs of the player controller
interface frogger_player_fsm_if #(
  parameter int POS_W   = 6,
  parameter int SCORE_W = 7
);
  logic               i_Up_Mvt;
  logic               i_Down_Mvt;
  logic               i_Left_Mvt;
  logic               i_Right_Mvt;
  logic               i_Collided;
  logic [3:0]         i_Tile_Data;
  logic               i_On_Log;
  logic               i_Log_Dir;
  logic [POS_W-1:0]   o_Frogger_X;
  logic [POS_W-1:0]   o_Frogger_Y;
  logic [SCORE_W-1:0] o_Score;
  logic [2:0]         o_Lives;
  logic               o_Dead;
  logic               o_Game_Over;
  logic               o_Score_Pulse;

  modport master (
    output i_Up_Mvt, i_Down_Mvt, i_Left_Mvt, i_Right_Mvt,
    output i_Collided, i_Tile_Data, i_On_Log, i_Log_Dir,
    input  o_Frogger_X, o_Frogger_Y, o_Score, o_Lives,
    input  o_Dead, o_Game_Over, o_Score_Pulse
  );

  modport slave (
    input  i_Up_Mvt, i_Down_Mvt, i_Left_Mvt, i_Right_Mvt,
    input  i_Collided, i_Tile_Data, i_On_Log, i_Log_Dir,
    output o_Frogger_X, o_Frogger_Y, o_Score, o_Lives,
    output o_Dead, o_Game_Over, o_Score_Pulse
  );
endinterface

// File: rtl/frogger_btn_edge.sv
// rtl/frogger_btn_edge.sv - four-channel rising-edge detector for the debounced buttons
module frogger_btn_edge (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn,
  output logic [3:0] rise
);

  logic [3:0] prev_q;
  logic [3:0] prev_d;

  always_comb begin
    prev_d = btn;
  end

  // Loading live levels during reset keeps a button held through reset from firing on release.
  always_ff @(posedge clk) begin
    if (rst) prev_q <= btn;
    else     prev_q <= prev_d;
  end

  assign rise = btn & ~prev_q;

endmodule

// File: rtl/frogger_player_fsm.sv
// rtl/frogger_player_fsm.sv - frog position, score, lives and PLAY/DYING/GAME_OVER state machine
module frogger_player_fsm #(
  parameter int         GAME_WIDTH      = frogger_pkg::DEF_GAME_WIDTH,
  parameter int         GAME_HEIGHT     = frogger_pkg::DEF_GAME_HEIGHT,
  parameter int         ORIG_X          = 10,
  parameter int         ORIG_Y          = 14,
  parameter int         POS_W           = 6,
  parameter int         SCORE_W         = 7,
  parameter int         LIVES           = 3,
  parameter int         LOG_DRIFT_COUNT = 39000000,
  parameter int         RESPAWN_COUNT   = 12500000,
  parameter logic [3:0] TILE_GOAL       = frogger_pkg::TILE_GOAL,
  parameter logic [3:0] TILE_WATER      = frogger_pkg::TILE_WATER
) (
  input logic                 i_Clk,
  input logic                 i_Reset,
  frogger_player_fsm_if.slave bus
);

  import frogger_pkg::state_e;
  import frogger_pkg::ST_PLAY;
  import frogger_pkg::ST_DYING;
  import frogger_pkg::ST_GAME_OVER;
  import frogger_pkg::BTN_UP;
  import frogger_pkg::BTN_DOWN;
  import frogger_pkg::BTN_LEFT;
  import frogger_pkg::BTN_RIGHT;

  localparam int DRIFT_W = (LOG_DRIFT_COUNT > 1) ? $clog2(LOG_DRIFT_COUNT) : 1;
  localparam int RESP_W  = (RESPAWN_COUNT > 1) ? $clog2(RESPAWN_COUNT) : 1;

  localparam logic [DRIFT_W-1:0] DRIFT_MAX = DRIFT_W'(LOG_DRIFT_COUNT - 1);
  localparam logic [DRIFT_W-1:0] DRIFT_ONE = DRIFT_W'(1);
  localparam logic [RESP_W-1:0]  RESP_MAX  = RESP_W'(RESPAWN_COUNT - 1);
  localparam logic [RESP_W-1:0]  RESP_ONE  = RESP_W'(1);
  localparam logic [POS_W-1:0]   X_MAX     = POS_W'(GAME_WIDTH - 1);
  localparam logic [POS_W-1:0]   Y_MAX     = POS_W'(GAME_HEIGHT - 1);
  localparam logic [POS_W-1:0]   X_ORIG    = POS_W'(ORIG_X);
  localparam logic [POS_W-1:0]   Y_ORIG    = POS_W'(ORIG_Y);
  localparam logic [POS_W-1:0]   POS_ONE   = POS_W'(1);
  localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};
  localparam logic [SCORE_W-1:0] SCORE_ONE = SCORE_W'(1);
  localparam logic [2:0]         LIVES_INIT = 3'(LIVES);

  state_e               state_q, state_d;
  logic [POS_W-1:0]     x_q, x_d, y_q, y_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [2:0]           lives_q, lives_d;
  logic                 moved_q, moved_d;
  logic                 pulse_q, pulse_d;
  logic                 dead_q, dead_d;
  logic                 over_q, over_d;
  logic [DRIFT_W-1:0]   drift_q, drift_d;
  logic [RESP_W-1:0]    resp_q, resp_d;

  logic [3:0]           rise;
  logic                 move_ok, move_taken;
  logic [POS_W-1:0]     move_x, move_y;
  logic                 drift_tick, drift_oob;
  logic                 water_death, goal_row, death, goal;

  frogger_btn_edge u_btn_edge (
    .clk  (i_Clk),
    .rst  (i_Reset),
    .btn  ({bus.i_Right_Mvt, bus.i_Left_Mvt, bus.i_Down_Mvt, bus.i_Up_Mvt}),
    .rise (rise)
  );

  // Highest-priority edge is selected first; a boundary then cancels it rather than passing to the next button.
  always_comb begin
    move_ok = 1'b0;
    move_x  = x_q;
    move_y  = y_q;
    if (rise[BTN_UP]) begin
      move_ok = (y_q != '0);
      move_y  = y_q - POS_ONE;
    end else if (rise[BTN_DOWN]) begin
      move_ok = (y_q != Y_MAX);
      move_y  = y_q + POS_ONE;
    end else if (rise[BTN_LEFT]) begin
      move_ok = (x_q != '0);
      move_x  = x_q - POS_ONE;
    end else if (rise[BTN_RIGHT]) begin
      move_ok = (x_q != X_MAX);
      move_x  = x_q + POS_ONE;
    end
  end

  // Tile-based checks wait one cycle after a position change because the tile lookup lags the position.
  assign drift_tick  = bus.i_On_Log && (drift_q == DRIFT_MAX);
  assign drift_oob   = bus.i_Log_Dir ? (x_q == X_MAX) : (x_q == '0);
  assign water_death = !moved_q && (bus.i_Tile_Data == TILE_WATER) && !bus.i_On_Log;
  assign goal_row    = !moved_q && (y_q == '0);
  assign death       = bus.i_Collided || water_death ||
                       (goal_row && (bus.i_Tile_Data != TILE_GOAL)) ||
                       (drift_tick && drift_oob);
  assign goal        = goal_row && (bus.i_Tile_Data == TILE_GOAL);

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    score_d    = score_q;
    lives_d    = lives_q;
    moved_d    = 1'b0;
    pulse_d    = 1'b0;
    drift_d    = '0;
    resp_d     = '0;
    move_taken = 1'b0;
    case (state_q)
      ST_PLAY: begin
        if (death) begin
          lives_d = lives_q - 3'd1;
          state_d = (lives_q == 3'd1) ? ST_GAME_OVER : ST_DYING;
          x_d     = X_ORIG;
          y_d     = Y_ORIG;
          moved_d = 1'b1;
        end else if (goal) begin
          if (score_q != SCORE_MAX) score_d = score_q + SCORE_ONE;
          pulse_d = 1'b1;
          x_d     = X_ORIG;
          y_d     = Y_ORIG;
          moved_d = 1'b1;
        end else if (move_ok) begin
          move_taken = 1'b1;
          x_d        = move_x;
          y_d        = move_y;
          moved_d    = 1'b1;
        end else if (drift_tick) begin
          x_d     = bus.i_Log_Dir ? (x_q + POS_ONE) : (x_q - POS_ONE);
          moved_d = 1'b1;
        end
        if (bus.i_On_Log && !move_taken) begin
          drift_d = drift_tick ? '0 : (drift_q + DRIFT_ONE);
        end
      end
      ST_DYING: begin
        x_d = X_ORIG;
        y_d = Y_ORIG;
        if (resp_q == RESP_MAX) begin
          state_d = ST_PLAY;
          moved_d = 1'b1;
        end else begin
          resp_d = resp_q + RESP_ONE;
        end
      end
      ST_GAME_OVER: begin
        x_d = X_ORIG;
        y_d = Y_ORIG;
        if (rise[BTN_UP]) begin
          state_d = ST_PLAY;
          score_d = '0;
          lives_d = LIVES_INIT;
          moved_d = 1'b1;
        end
      end
      default: state_d = ST_PLAY;
    endcase
    dead_d = (state_d == ST_DYING);
    over_d = (state_d == ST_GAME_OVER);
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_q <= ST_PLAY;
      x_q     <= X_ORIG;
      y_q     <= Y_ORIG;
      score_q <= '0;
      lives_q <= LIVES_INIT;
      moved_q <= 1'b0;
      pulse_q <= 1'b0;
      dead_q  <= 1'b0;
      over_q  <= 1'b0;
      drift_q <= '0;
      resp_q  <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      score_q <= score_d;
      lives_q <= lives_d;
      moved_q <= moved_d;
      pulse_q <= pulse_d;
      dead_q  <= dead_d;
      over_q  <= over_d;
      drift_q <= drift_d;
      resp_q  <= resp_d;
    end
  end

  assign bus.o_Frogger_X   = x_q;
  assign bus.o_Frogger_Y   = y_q;
  assign bus.o_Score       = score_q;
  assign bus.o_Lives       = lives_q;
  assign bus.o_Dead        = dead_q;
  assign bus.o_Game_Over   = over_q;
  assign bus.o_Score_Pulse = pulse_q;

endmodule

// File: tb/tb_frogger_player_fsm.sv
// tb/tb_frogger_player_fsm.sv - directed self-checking bench for frogger_player_fsm
module tb_frogger_player_fsm;

  localparam int POS_W   = 6;
  localparam int SCORE_W = 7;
  localparam int DRIFT   = 8;
  localparam int RESP    = 5;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   pulse_seen;
  int   dead_cycles;

  frogger_player_fsm_if #(.POS_W(POS_W), .SCORE_W(SCORE_W)) bus ();

  frogger_player_fsm #(
    .GAME_WIDTH      (20),
    .GAME_HEIGHT     (15),
    .ORIG_X          (10),
    .ORIG_Y          (14),
    .POS_W           (POS_W),
    .SCORE_W         (SCORE_W),
    .LIVES           (3),
    .LOG_DRIFT_COUNT (DRIFT),
    .RESPAWN_COUNT   (RESP),
    .TILE_GOAL       (4'd4),
    .TILE_WATER      (4'd2)
  ) dut (
    .i_Clk   (clk),
    .i_Reset (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      0:       bus.i_Up_Mvt    = v;
      1:       bus.i_Down_Mvt  = v;
      2:       bus.i_Left_Mvt  = v;
      default: bus.i_Right_Mvt = v;
    endcase
  endtask

  task automatic press(input int b);
    set_btn(b, 1'b1);
    cyc(1);
    set_btn(b, 1'b0);
    cyc(1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(1);
  endtask

  // From (10,14): climb to row 0 over a goal tile; the goal is taken two edges after arrival.
  task automatic goal_run();
    for (int i = 0; i < 13; i++) press(0);
    bus.i_Up_Mvt    = 1'b1;
    bus.i_Tile_Data = 4'd4;
    cyc(1);
    bus.i_Up_Mvt = 1'b0;
    pulse_seen   = int'(bus.o_Score_Pulse);
    cyc(1);
    pulse_seen += int'(bus.o_Score_Pulse);
    cyc(1);
    pulse_seen += int'(bus.o_Score_Pulse);
    bus.i_Tile_Data = 4'd0;
    cyc(1);
    pulse_seen += int'(bus.o_Score_Pulse);
  endtask

  task automatic wait_alive(input string tag);
    for (int i = 0; i < 40 && bus.o_Dead; i++) cyc(1);
    check(tag, int'(bus.o_Dead), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst             = 1'b1;
    bus.i_Up_Mvt    = 1'b0;
    bus.i_Down_Mvt  = 1'b0;
    bus.i_Left_Mvt  = 1'b0;
    bus.i_Right_Mvt = 1'b0;
    bus.i_Collided  = 1'b0;
    bus.i_Tile_Data = 4'd0;
    bus.i_On_Log    = 1'b0;
    bus.i_Log_Dir   = 1'b0;
    cyc(2);
    check("rst_x",     int'(bus.o_Frogger_X), 10);
    check("rst_y",     int'(bus.o_Frogger_Y), 14);
    check("rst_score", int'(bus.o_Score), 0);
    check("rst_lives", int'(bus.o_Lives), 3);
    check("rst_dead",  int'(bus.o_Dead), 0);
    check("rst_over",  int'(bus.o_Game_Over), 0);
    check("rst_pulse", int'(bus.o_Score_Pulse), 0);
    rst = 1'b0;
    cyc(1);

    // Single up edge, then a long hold
    bus.i_Up_Mvt = 1'b1;
    cyc(1);
    check("up_once", int'(bus.o_Frogger_Y), 13);
    cyc(100);
    check("up_hold", int'(bus.o_Frogger_Y), 13);
    bus.i_Up_Mvt = 1'b0;
    cyc(1);

    // Up held through reset must not move the frog
    bus.i_Up_Mvt = 1'b1;
    do_reset();
    cyc(2);
    check("up_thru_rst", int'(bus.o_Frogger_Y), 14);
    bus.i_Up_Mvt = 1'b0;
    cyc(1);
    check("up_release", int'(bus.o_Frogger_Y), 14);

    // Playfield edges
    for (int i = 0; i < 9; i++) press(3);
    check("right_to_19", int'(bus.o_Frogger_X), 19);
    press(3);
    check("right_edge", int'(bus.o_Frogger_X), 19);
    for (int i = 0; i < 19; i++) press(2);
    check("left_to_0", int'(bus.o_Frogger_X), 0);
    press(2);
    check("left_edge", int'(bus.o_Frogger_X), 0);
    press(1);
    check("down_edge", int'(bus.o_Frogger_Y), 14);
    press(3);
    bus.i_Up_Mvt   = 1'b1;
    bus.i_Left_Mvt = 1'b1;
    cyc(1);
    check("up_left_x", int'(bus.o_Frogger_X), 1);
    check("up_left_y", int'(bus.o_Frogger_Y), 13);
    bus.i_Up_Mvt   = 1'b0;
    bus.i_Left_Mvt = 1'b0;
    cyc(1);

    // Goal scoring and saturation
    do_reset();
    goal_run();
    check("goal_pulse", pulse_seen, 1);
    check("goal_score", int'(bus.o_Score), 1);
    check("goal_x", int'(bus.o_Frogger_X), 10);
    check("goal_y", int'(bus.o_Frogger_Y), 14);
    check("goal_lives", int'(bus.o_Lives), 3);
    for (int i = 0; i < 126; i++) goal_run();
    check("score_127", int'(bus.o_Score), 127);
    goal_run();
    check("score_sat", int'(bus.o_Score), 127);
    check("sat_pulse", pulse_seen, 1);

    // Log drift over water, then falling in
    do_reset();
    bus.i_Tile_Data = 4'd2;
    bus.i_On_Log    = 1'b1;
    bus.i_Log_Dir   = 1'b0;
    cyc(7);
    check("drift_pre", int'(bus.o_Frogger_X), 10);
    cyc(1);
    check("drift_1", int'(bus.o_Frogger_X), 9);
    cyc(8);
    check("drift_2", int'(bus.o_Frogger_X), 8);
    cyc(1);
    check("drift_hold", int'(bus.o_Frogger_X), 8);
    bus.i_On_Log = 1'b0;
    cyc(1);
    check("water_lives", int'(bus.o_Lives), 2);
    check("water_dead", int'(bus.o_Dead), 1);
    check("water_x", int'(bus.o_Frogger_X), 10);
    bus.i_Tile_Data = 4'd0;
    dead_cycles = 1;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      if (bus.o_Dead) dead_cycles++;
      else break;
    end
    check("dead_len", dead_cycles, RESP);
    check("respawn_alive", int'(bus.o_Dead), 0);

    // Three collisions to game over, then restart
    do_reset();
    goal_run();
    for (int k = 0; k < 3; k++) begin
      bus.i_Collided = 1'b1;
      cyc(1);
      bus.i_Collided = 1'b0;
      check("coll_lives", int'(bus.o_Lives), 2 - k);
      if (k < 2) begin
        check("coll_dead", int'(bus.o_Dead), 1);
        wait_alive("coll_respawn");
      end
    end
    check("go_flag", int'(bus.o_Game_Over), 1);
    check("go_dead", int'(bus.o_Dead), 0);
    check("go_score", int'(bus.o_Score), 1);
    press(1);
    press(2);
    press(3);
    check("go_ign_x", int'(bus.o_Frogger_X), 10);
    check("go_ign_y", int'(bus.o_Frogger_Y), 14);
    check("go_ign_flag", int'(bus.o_Game_Over), 1);
    bus.i_Up_Mvt = 1'b1;
    cyc(1);
    check("restart_over", int'(bus.o_Game_Over), 0);
    check("restart_lives", int'(bus.o_Lives), 3);
    check("restart_score", int'(bus.o_Score), 0);
    check("restart_y", int'(bus.o_Frogger_Y), 14);
    bus.i_Up_Mvt = 1'b0;
    cyc(1);
    press(0);
    check("restart_move", int'(bus.o_Frogger_Y), 13);

    // Reset in the middle of DYING
    bus.i_Collided = 1'b1;
    cyc(1);
    bus.i_Collided = 1'b0;
    check("mid_dying", int'(bus.o_Dead), 1);
    cyc(2);
    rst = 1'b1;
    cyc(1);
    check("rdie_dead", int'(bus.o_Dead), 0);
    check("rdie_lives", int'(bus.o_Lives), 3);
    check("rdie_x", int'(bus.o_Frogger_X), 10);
    check("rdie_y", int'(bus.o_Frogger_Y), 14);
    rst = 1'b0;
    cyc(1);
    press(0);
    check("rdie_play", int'(bus.o_Frogger_Y), 13);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
